// File: rtl/sort_feeder.sv
// sort_feeder: buffers whole input packets in a two-bank ping-pong RAM and replays each
// complete packet to the sorter as one burst. Define SORT_FEEDER_STATS_EN to add fwd_cnt_o.
module sort_feeder #(
    parameter int unsigned DWIDTH    = 8,
    parameter int unsigned AWIDTH    = 3,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 srst_i,
    input  logic [DWIDTH-1:0]    data_i,
    input  logic                 sop_i,
    input  logic                 eop_i,
    input  logic                 val_i,
    output logic                 ready_o,
    output logic [DWIDTH-1:0]    data_o,
    output logic                 sop_o,
    output logic                 eop_o,
    output logic                 val_o,
    input  logic                 sort_busy_i,
`ifdef SORT_FEEDER_STATS_EN
    output logic [CNT_WIDTH-1:0] fwd_cnt_o,
`endif
    output logic [CNT_WIDTH-1:0] drop_cnt_o
);

    localparam int unsigned MAX_LEN = 1 << AWIDTH;
    localparam int unsigned LW      = AWIDTH + 1;

    typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL} bank_st_t;
    typedef enum logic [1:0] {IDLE, RECV, DISCARD} rx_st_t;
    typedef enum logic [1:0] {TX_IDLE, SEND, WAIT_HI, WAIT_LO} tx_st_t;

    bank_st_t          bank_st  [2];
    logic [LW-1:0]     bank_len [2];
    logic [DWIDTH-1:0] mem      [2][MAX_LEN];

    rx_st_t            rx_st;
    tx_st_t            tx_st;
    logic              wr_bank;
    logic              rd_bank;
    logic [LW-1:0]     wr_ptr;
    logic [AWIDTH-1:0] rd_ptr;

    logic              free_c;
    logic              overflow_c;
    logic              start_c;
    logic              cont_c;
    logic              drop_c;
    logic [AWIDTH-1:0] wr_addr_c;
    logic              tx_go_c;
    logic              tx_emit_c;
    logic              tx_last_c;

    // A bank released by the tx side this cycle counts as free for an rx sop.
    always_comb begin
        free_c     = (bank_st[wr_bank] == B_EMPTY) ||
                     (tx_st == WAIT_LO && !sort_busy_i && rd_bank == wr_bank);
        overflow_c = (wr_ptr == LW'(MAX_LEN));
        start_c    = val_i && sop_i && (rx_st == RECV || (rx_st == IDLE && free_c));
        cont_c     = val_i && !sop_i && rx_st == RECV && !overflow_c;
        drop_c     = val_i && ((sop_i && rx_st == RECV) ||
                               (sop_i && rx_st == IDLE && !free_c) ||
                               (!sop_i && rx_st == RECV && overflow_c));
        wr_addr_c  = start_c ? '0 : wr_ptr[AWIDTH-1:0];
        tx_go_c    = tx_st == TX_IDLE && bank_st[rd_bank] == B_FULL && !sort_busy_i;
        tx_emit_c  = tx_go_c || tx_st == SEND;
        tx_last_c  = (LW'(rd_ptr) == bank_len[rd_bank] - LW'(1));
    end

    always_ff @(posedge clk_i) begin
        if (!srst_i && (start_c || cont_c)) begin
            mem[wr_bank][wr_addr_c] <= data_i;
        end
    end

    // Rx and tx FSMs, bank bookkeeping and registered outputs.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            rx_st      <= IDLE;
            tx_st      <= TX_IDLE;
            for (int b = 0; b < 2; b++) begin
                bank_st[b]  <= B_EMPTY;
                bank_len[b] <= '0;
            end
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ready_o    <= 1'b0;
            data_o     <= '0;
            sop_o      <= 1'b0;
            eop_o      <= 1'b0;
            val_o      <= 1'b0;
            drop_cnt_o <= '0;
        end else begin
            ready_o <= (bank_st[0] == B_EMPTY) || (bank_st[1] == B_EMPTY);
            data_o  <= '0;
            sop_o   <= 1'b0;
            eop_o   <= 1'b0;
            val_o   <= 1'b0;

            if (drop_c && drop_cnt_o != '1) begin
                drop_cnt_o <= drop_cnt_o + CNT_WIDTH'(1);
            end

            if (tx_emit_c) begin
                val_o  <= 1'b1;
                sop_o  <= (tx_st == TX_IDLE);
                eop_o  <= tx_last_c;
                data_o <= mem[rd_bank][rd_ptr];
                if (tx_last_c) begin
                    rd_ptr <= '0;
                    tx_st  <= WAIT_HI;
                end else begin
                    rd_ptr <= rd_ptr + AWIDTH'(1);
                    tx_st  <= SEND;
                end
            end else begin
                case (tx_st)
                    WAIT_HI: if (sort_busy_i) tx_st <= WAIT_LO;
                    WAIT_LO: begin
                        if (!sort_busy_i) begin
                            bank_st[rd_bank] <= B_EMPTY;
                            rd_bank          <= ~rd_bank;
                            tx_st            <= TX_IDLE;
                        end
                    end
                    default: ;
                endcase
            end

            // Rx updates come after tx so a same-cycle reuse of a freed bank wins.
            if (start_c) begin
                bank_st[wr_bank] <= eop_i ? B_FULL : B_FILLING;
                if (eop_i) begin
                    bank_len[wr_bank] <= LW'(1);
                    wr_bank           <= ~wr_bank;
                    rx_st             <= IDLE;
                end else begin
                    wr_ptr <= LW'(1);
                    rx_st  <= RECV;
                end
            end else begin
                case (rx_st)
                    IDLE: if (val_i && sop_i && !eop_i) rx_st <= DISCARD;
                    RECV: begin
                        if (val_i) begin
                            if (overflow_c) begin
                                bank_st[wr_bank] <= B_EMPTY;
                                rx_st            <= eop_i ? IDLE : DISCARD;
                            end else begin
                                wr_ptr <= wr_ptr + LW'(1);
                                if (eop_i) begin
                                    bank_st[wr_bank]  <= B_FULL;
                                    bank_len[wr_bank] <= wr_ptr + LW'(1);
                                    wr_bank           <= ~wr_bank;
                                    rx_st             <= IDLE;
                                end
                            end
                        end
                    end
                    DISCARD: if (val_i && eop_i) rx_st <= IDLE;
                    default: rx_st <= IDLE;
                endcase
            end
        end
    end

`ifdef SORT_FEEDER_STATS_EN
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            fwd_cnt_o <= '0;
        end else if (tx_emit_c && tx_last_c) begin
            fwd_cnt_o <= fwd_cnt_o + CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_sort_feeder.sv
// Self-checking bench for sort_feeder: directed packet table plus hand-written
// sequences for buffering, restart, reset and a randomized stream.
module tb_sort_feeder;

    logic        clk = 1'b0;
    logic        srst;
    logic [7:0]  in_data;
    logic        in_sop, in_eop, in_val;
    logic        ready;
    logic [7:0]  out_data;
    logic        out_sop, out_eop, out_val;
    logic        busy;
    logic [15:0] drop_cnt;
`ifdef SORT_FEEDER_STATS_EN
    logic [15:0] fwd_cnt;
`endif

    always #5 clk = ~clk;

    sort_feeder #(.DWIDTH(8), .AWIDTH(3), .CNT_WIDTH(16)) dut (
        .clk_i       (clk),
        .srst_i      (srst),
        .data_i      (in_data),
        .sop_i       (in_sop),
        .eop_i       (in_eop),
        .val_i       (in_val),
        .ready_o     (ready),
        .data_o      (out_data),
        .sop_o       (out_sop),
        .eop_o       (out_eop),
        .val_o       (out_val),
        .sort_busy_i (busy),
`ifdef SORT_FEEDER_STATS_EN
        .fwd_cnt_o   (fwd_cnt),
`endif
        .drop_cnt_o  (drop_cnt)
    );

    // Sorter model: busy the cycle after it receives eop, for three cycles.
    logic hold_busy = 1'b0;
    int   busy_cnt  = 0;
    int   cyc       = 0;
    assign busy = hold_busy || (busy_cnt != 0);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (out_val && out_eop) busy_cnt <= 3;
        else if (busy_cnt > 0)  busy_cnt <= busy_cnt - 1;
    end

    logic [7:0] got_d[$];
    bit         got_s[$], got_e[$];
    logic [7:0] exp_d[$];
    bit         exp_s[$], exp_e[$];
    int         idle_viol = 0;
    int         first_val = -1;
    int         eop_edge  = 0;

    always @(negedge clk) begin
        if (out_val) begin
            got_d.push_back(out_data);
            got_s.push_back(out_sop);
            got_e.push_back(out_eop);
            if (first_val < 0) first_val = cyc;
        end else if (out_sop || out_eop || out_data != 8'h00) begin
            idle_viol++;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    logic [7:0] pkt [16];

    task automatic put(input bit v, input bit s, input bit e, input logic [7:0] d);
        in_val = v; in_sop = s; in_eop = e; in_data = d;
        @(posedge clk); #1;
        in_val = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = 8'h00;
    endtask

    task automatic send_pkt(input int n);
        for (int i = 0; i < n; i++) put(1'b1, i == 0, i == n - 1, pkt[i]);
        eop_edge = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic expect_pkt(input int n);
        for (int i = 0; i < n; i++) begin
            exp_d.push_back(pkt[i]);
            exp_s.push_back(i == 0);
            exp_e.push_back(i == n - 1);
        end
    endtask

    task automatic compare(input string name);
        int n;
        check({name, " count"}, got_d.size(), exp_d.size());
        n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s w%0d data", name, i), 32'(got_d[i]), 32'(exp_d[i]));
            check($sformatf("%s w%0d sop/eop", name, i), {got_s[i], got_e[i]}, {exp_s[i], exp_e[i]});
        end
        got_d.delete(); got_s.delete(); got_e.delete();
        exp_d.delete(); exp_s.delete(); exp_e.delete();
    endtask

    typedef struct {
        int               len;
        logic [0:11][7:0] w;
        bit               fwd;
        int               drop;
    } vec_t;

    function automatic vec_t mk(input int len, input logic [0:11][7:0] w, input bit fwd, input int drop);
        vec_t r;
        r.len = len; r.w = w; r.fwd = fwd; r.drop = drop;
        return r;
    endfunction

    vec_t vec [8];
    int   exp_drop;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0] = mk(5,  {8'd10, 8'd3, 8'd7, 8'd1, 8'd9, 56'd0}, 1'b1, 0);
        vec[1] = mk(1,  {8'h55, 88'd0}, 1'b1, 0);
        vec[2] = mk(9,  {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 24'd0}, 1'b0, 1);
        vec[3] = mk(8,  {8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87, 32'd0}, 1'b1, 1);
        vec[4] = mk(2,  {8'hAA, 8'h00, 80'd0}, 1'b1, 1);
        vec[5] = mk(8,  {8'hFF, 8'h00, 8'hFF, 8'h00, 8'h5A, 8'hA5, 8'h01, 8'hFE, 32'd0}, 1'b1, 1);
        vec[6] = mk(10, {8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19, 16'd0}, 1'b0, 2);
        vec[7] = mk(3,  {8'hC1, 8'hC2, 8'hC3, 72'd0}, 1'b1, 2);

        srst = 1'b1; in_val = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = 8'h00;
        idle(3);
        check("reset val_o", out_val, 0);
        check("reset sop/eop", {out_sop, out_eop}, 0);
        check("reset data_o", out_data, 0);
        check("reset drop_cnt", drop_cnt, 0);
        check("reset ready_o", ready, 0);
`ifdef SORT_FEEDER_STATS_EN
        check("reset fwd_cnt", fwd_cnt, 0);
`endif
        srst = 1'b0;
        idle(1);
        check("ready after reset", ready, 1);

        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < vec[v].len; i++) pkt[i] = vec[v].w[i];
            first_val = -1;
            send_pkt(vec[v].len);
            if (vec[v].fwd) expect_pkt(vec[v].len);
            idle(25);
            compare($sformatf("vec%0d", v));
            check($sformatf("vec%0d drop_cnt", v), drop_cnt, vec[v].drop);
            check($sformatf("vec%0d ready", v), ready, 1);
            if (vec[v].fwd) check($sformatf("vec%0d latency", v), first_val, eop_edge + 1);
        end
        exp_drop = 2;

        // Two packets buffered while the sorter is busy; the third finds no bank.
        hold_busy = 1'b1;
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 4; i++) pkt[i] = 8'(8'h31 + 8'(p * 16) + 8'(i));
            send_pkt(4);
        end
        idle(5);
        check("busy hold ready", ready, 0);
        check("busy hold drop_cnt", drop_cnt, exp_drop + 1);
        check("busy hold no output", got_d.size(), 0);
        exp_drop++;
        hold_busy = 1'b0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 4; i++) pkt[i] = 8'(8'h31 + 8'(p * 16) + 8'(i));
            expect_pkt(4);
        end
        idle(40);
        compare("buffered");
        check("buffered ready", ready, 1);

        // sop re-asserted at word 3 restarts the packet.
        put(1'b1, 1'b1, 1'b0, 8'h11);
        put(1'b1, 1'b0, 1'b0, 8'h12);
        put(1'b1, 1'b0, 1'b0, 8'h13);
        put(1'b1, 1'b1, 1'b0, 8'h21);
        put(1'b1, 1'b0, 1'b0, 8'h22);
        put(1'b1, 1'b0, 1'b0, 8'h23);
        put(1'b1, 1'b0, 1'b1, 8'h24);
        for (int i = 0; i < 4; i++) pkt[i] = 8'(8'h21 + i);
        expect_pkt(4);
        idle(25);
        compare("restart");
        check("restart drop_cnt", drop_cnt, exp_drop + 1);
        exp_drop++;

        // Reset while a burst is in flight.
        for (int i = 0; i < 8; i++) pkt[i] = 8'(8'h61 + i);
        send_pkt(8);
        begin
            bit seen = 1'b0;
            for (int k = 0; k < 10 && !seen; k++) begin
                @(negedge clk);
                seen = out_val;
            end
            check("burst started before reset", seen, 1);
        end
        srst = 1'b1;
        @(posedge clk); #1;
        check("reset mid-send val_o", out_val, 0);
        check("reset mid-send drop_cnt", drop_cnt, 0);
        srst = 1'b0;
        got_d.delete(); got_s.delete(); got_e.delete();
        idle(30);
        check("no replay after reset", got_d.size(), 0);
        for (int i = 0; i < 3; i++) pkt[i] = 8'(8'h71 + i);
        send_pkt(3);
        expect_pkt(3);
        idle(25);
        compare("after reset");

        // Randomized stream of 3..7-word packets from a clean reset.
        srst = 1'b1;
        idle(2);
        srst = 1'b0;
        idle(2);
        for (int p = 0; p < 100; p++) begin
            int len;
            len = int'($urandom_range(7, 3));
            for (int i = 0; i < len; i++) pkt[i] = 8'($urandom);
            send_pkt(len);
            expect_pkt(len);
            idle(10);
        end
        idle(40);
        compare("random");
        check("random drop_cnt", drop_cnt, 0);
`ifdef SORT_FEEDER_STATS_EN
        check("random fwd_cnt", fwd_cnt, 100);
`endif
        check("idle outputs zero", idle_viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
